axi_burst_readn: RTL and testbench

- Pipelined successor to the single-outstanding burst reader: accepts one AXI-style read burst (addr, 0-based length) and issues single-beat reads to a subordinate at a configurable address stride.
- Keeps up to DEPTH beats in flight or buffered.
- Streams results to the manager with no inter-beat bubble and forwards per-beat rresp.
- Accepts the next burst while the previous one drains.
- Sits between frame-buffer/line readers and striped SRAM/AXI subordinates.

---
 rtl/axi_burst_readn_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/axi_burst_readn.sv | 158 +++++++++++++++
 tb/tb_axi_burst_readn.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_readn_pkg.sv
// Shared types and constants for the pipelined burst reader.
// Holds FSM encodings, AXI response codes and the result-buffer entry layout.
package axi_burst_readn_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned ENTRY_DATA_W = 16;

  // One buffered beat as presented to the manager.
  typedef struct packed {
    logic                    last;
    logic [1:0]              resp;
    logic [ENTRY_DATA_W-1:0] data;
  } result_entry_t;

  function automatic logic resp_is_error(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

  function automatic logic resp_is_ok(input logic [1:0] resp);
    return (resp == RESP_OKAY) || (resp == RESP_EXOKAY);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-two depth, optional show-ahead read port.
// Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 8,
  parameter bit          SHOW_AHEAD = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data_c,
  output logic             empty_c,
  output logic             full_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer bit distinguishes full from empty.
  assign empty_c = (wr_q == rd_q);
  assign full_c  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push_ok = push && !full_c;
  assign pop_ok  = pop && !empty_c;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + PW'(1);
      if (pop_ok)  rd_q <= rd_q + PW'(1);
    end
  end

  generate
    if (SHOW_AHEAD) begin : g_show_ahead
      assign pop_data_c = mem[rd_q[AW-1:0]];
    end else begin : g_registered
      logic [WIDTH-1:0] data_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      data_q <= '0;
        else if (pop_ok) data_q <= mem[rd_q[AW-1:0]];
      end
      assign pop_data_c = data_q;
    end
  endgenerate

endmodule

// File: rtl/axi_burst_readn.sv
// Splits one AXI read burst into strided single-beat reads, keeping up to DEPTH
// beats in flight or buffered, and streams the ordered results back with rlast.
module axi_burst_readn
  import axi_burst_readn_pkg::*;
#(
  parameter int unsigned STRIDE          = 2,
  parameter int unsigned AXI_ADDR_WIDTH  = 20,
  parameter int unsigned AXI_DATA_WIDTH  = 16,
  parameter int unsigned AXI_ARLEN_WIDTH = 8,
  parameter int unsigned DEPTH           = 8
) (
  input  logic                       axi_clk,
  input  logic                       axi_resetn,
  input  logic [AXI_ADDR_WIDTH-1:0]  in_axi_araddr,
  input  logic [AXI_ARLEN_WIDTH-1:0] in_axi_arlen,
  input  logic                       in_axi_arvalid,
  output logic                       in_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]  in_axi_rdata,
  output logic [1:0]                 in_axi_rresp,
  output logic                       in_axi_rvalid,
  output logic                       in_axi_rlast,
  input  logic                       in_axi_rready,
  output logic [AXI_ADDR_WIDTH-1:0]  out_axi_araddr,
  output logic                       out_axi_arvalid,
  input  logic                       out_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]  out_axi_rdata,
  input  logic [1:0]                 out_axi_rresp,
  input  logic                       out_axi_rvalid,
  output logic                       out_axi_rready
);

  localparam int unsigned CRED_W  = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = 3 + AXI_DATA_WIDTH;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(DEPTH);

  logic [1:0]                 state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [AXI_ARLEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [CRED_W-1:0]          credits_q, credits_d;
  logic                       arvalid_q, arvalid_d;
  logic                       arready_q, arready_d;
  logic                       rready_q;

  logic                       in_hs, out_hs, r_hs;
  logic                       meta_empty, meta_full, meta_last;
  logic                       res_empty, res_full;
  logic                       beat_take;
  logic [ENTRY_W-1:0]         res_head;

  assign in_hs  = in_axi_arvalid && arready_q;
  assign out_hs = arvalid_q && out_axi_arready;
  assign r_hs   = !res_empty && in_axi_rready;
  // Responses with no matching meta entry are leftovers from before a reset.
  assign beat_take = out_axi_rvalid && !meta_empty && !res_full;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    credits_d   = credits_q;

    case (state_q)
      ST_IDLE: begin
        if (in_hs) begin
          addr_d      = in_axi_araddr;
          remaining_d = in_axi_arlen;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (out_hs) begin
          addr_d      = addr_q + AXI_ADDR_WIDTH'(STRIDE);
          remaining_d = remaining_q - AXI_ARLEN_WIDTH'(1);
          if (remaining_q == '0) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (in_hs) begin
          addr_d      = in_axi_araddr;
          remaining_d = in_axi_arlen;
          state_d     = ST_ISSUE;
        end else if (r_hs && in_axi_rlast) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (out_hs && !r_hs)      credits_d = credits_q - CRED_W'(1);
    else if (!out_hs && r_hs) credits_d = credits_q + CRED_W'(1);

    // Credits gate only the rising edge of arvalid; an issued address is held.
    arvalid_d = (arvalid_q && !out_hs) ||
                ((state_d == ST_ISSUE) && (credits_d != '0) && !meta_full);
    arready_d = (state_d != ST_ISSUE);
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      credits_q   <= CRED_MAX;
      arvalid_q   <= 1'b0;
      arready_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      credits_q   <= credits_d;
      arvalid_q   <= arvalid_d;
      arready_q   <= arready_d;
      rready_q    <= 1'b1;
    end
  end

  // Tracks the rlast flag of every address issued but not yet answered.
  sync_fifo #(
    .WIDTH      (1),
    .DEPTH      (DEPTH),
    .SHOW_AHEAD (1'b1)
  ) u_meta_fifo (
    .clk        (axi_clk),
    .rst_n      (axi_resetn),
    .push       (out_hs),
    .push_data  (remaining_q == '0),
    .pop        (beat_take),
    .pop_data_c (meta_last),
    .empty_c    (meta_empty),
    .full_c     (meta_full)
  );

  sync_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH      (DEPTH),
    .SHOW_AHEAD (1'b1)
  ) u_result_fifo (
    .clk        (axi_clk),
    .rst_n      (axi_resetn),
    .push       (beat_take),
    .push_data  ({meta_last, out_axi_rresp, out_axi_rdata}),
    .pop        (r_hs),
    .pop_data_c (res_head),
    .empty_c    (res_empty),
    .full_c     (res_full)
  );

  assign in_axi_arready  = arready_q;
  assign in_axi_rvalid   = !res_empty;
  assign in_axi_rdata    = res_empty ? '0 : res_head[AXI_DATA_WIDTH-1:0];
  assign in_axi_rresp    = res_empty ? RESP_OKAY : res_head[AXI_DATA_WIDTH +: 2];
  assign in_axi_rlast    = !res_empty && res_head[ENTRY_W-1];
  assign out_axi_araddr  = addr_q;
  assign out_axi_arvalid = arvalid_q;
  assign out_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_burst_readn.sv
// Scoreboard bench for axi_burst_readn: a 1-cycle subordinate model answers reads,
// expected addresses and beats are queued at request time and compared in order.
module tb_axi_burst_readn;
  import axi_burst_readn_pkg::*;

  localparam int unsigned AW     = 20;
  localparam int unsigned DW     = 16;
  localparam int unsigned LW     = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned STRIDE = 2;

  logic          axi_clk = 1'b0;
  logic          axi_resetn;
  logic [AW-1:0] in_axi_araddr;
  logic [LW-1:0] in_axi_arlen;
  logic          in_axi_arvalid, in_axi_arready;
  logic [DW-1:0] in_axi_rdata;
  logic [1:0]    in_axi_rresp;
  logic          in_axi_rvalid, in_axi_rlast, in_axi_rready;
  logic [AW-1:0] out_axi_araddr;
  logic          out_axi_arvalid, out_axi_arready;
  logic [DW-1:0] out_axi_rdata;
  logic [1:0]    out_axi_rresp;
  logic          out_axi_rvalid, out_axi_rready;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [AW-1:0] pend[$];
  logic [AW-1:0] ar_seen[$];
  logic [AW-1:0] ar_exp[$];
  result_entry_t r_seen[$];
  result_entry_t r_exp[$];
  int            r_cyc[$];
  logic          err_en   = 1'b0;
  logic [AW-1:0] err_addr = '0;
  logic [AW-1:0] sub_a;
  result_entry_t obs;

  axi_burst_readn #(
    .STRIDE(STRIDE), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
    .AXI_ARLEN_WIDTH(LW), .DEPTH(DEPTH)
  ) dut (
    .axi_clk(axi_clk), .axi_resetn(axi_resetn),
    .in_axi_araddr(in_axi_araddr), .in_axi_arlen(in_axi_arlen),
    .in_axi_arvalid(in_axi_arvalid), .in_axi_arready(in_axi_arready),
    .in_axi_rdata(in_axi_rdata), .in_axi_rresp(in_axi_rresp),
    .in_axi_rvalid(in_axi_rvalid), .in_axi_rlast(in_axi_rlast),
    .in_axi_rready(in_axi_rready),
    .out_axi_araddr(out_axi_araddr), .out_axi_arvalid(out_axi_arvalid),
    .out_axi_arready(out_axi_arready), .out_axi_rdata(out_axi_rdata),
    .out_axi_rresp(out_axi_rresp), .out_axi_rvalid(out_axi_rvalid),
    .out_axi_rready(out_axi_rready)
  );

  always #5 axi_clk = ~axi_clk;
  always @(posedge axi_clk) cyc++;

  function automatic logic [DW-1:0] sub_data(input logic [AW-1:0] a);
    return DW'(a) ^ 16'h5A5A;
  endfunction

  // Subordinate answers each accepted address one cycle later; also records both interfaces.
  always @(negedge axi_clk) begin
    if (pend.size() > 0) begin
      sub_a          = pend.pop_front();
      out_axi_rvalid = 1'b1;
      out_axi_rdata  = sub_data(sub_a);
      out_axi_rresp  = (err_en && sub_a == err_addr) ? 2'b10 : 2'b00;
    end else begin
      out_axi_rvalid = 1'b0;
      out_axi_rdata  = '0;
      out_axi_rresp  = 2'b00;
    end
    if (out_axi_arvalid && out_axi_arready) begin
      pend.push_back(out_axi_araddr);
      ar_seen.push_back(out_axi_araddr);
    end
    if (in_axi_rvalid && in_axi_rready) begin
      obs = {in_axi_rlast, in_axi_rresp, in_axi_rdata};
      r_seen.push_back(obs);
      r_cyc.push_back(cyc);
    end
  end

  task automatic clear_queues();
    ar_seen.delete(); ar_exp.delete(); r_seen.delete(); r_exp.delete(); r_cyc.delete();
  endtask

  task automatic expect_burst(input logic [AW-1:0] base, input int len);
    logic [AW-1:0] a;
    result_entry_t e;
    a = base;
    for (int i = 0; i <= len; i++) begin
      ar_exp.push_back(a);
      e.last = (i == len);
      e.resp = (err_en && a == err_addr) ? RESP_SLVERR : RESP_OKAY;
      e.data = sub_data(a);
      r_exp.push_back(e);
      a = a + AW'(STRIDE);
    end
  endtask

  task automatic send_req(input logic [AW-1:0] a, input logic [LW-1:0] len, output bit ok);
    int w;
    w = 0;
    in_axi_araddr = a; in_axi_arlen = len; in_axi_arvalid = 1'b1;
    @(negedge axi_clk);
    while (!in_axi_arready && w < 60) begin @(negedge axi_clk); w++; end
    ok = in_axi_arready;
    @(posedge axi_clk); #1;
    in_axi_arvalid = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    int w;
    w = 0;
    while (r_seen.size() < n && w < budget) begin @(posedge axi_clk); #1; w++; end
    ok = (r_seen.size() >= n);
  endtask

  task automatic test_reset();
    axi_resetn = 1'b0; in_axi_arvalid = 1'b0; in_axi_rready = 1'b0;
    in_axi_araddr = '0; in_axi_arlen = '0; out_axi_arready = 1'b1;
    #12;
    n_checks++;
    if ({in_axi_arready, in_axi_rvalid, in_axi_rlast, out_axi_arvalid, out_axi_rready} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: arready/rvalid/rlast/arvalid/rready=%b expected 00000",
               {in_axi_arready, in_axi_rvalid, in_axi_rlast, out_axi_arvalid, out_axi_rready});
    end
    n_checks++;
    if ({in_axi_rdata, in_axi_rresp, out_axi_araddr} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%h rresp=%b araddr=%h expected all zero", in_axi_rdata, in_axi_rresp, out_axi_araddr);
    end
    @(posedge axi_clk); #1 axi_resetn = 1'b1;
    @(posedge axi_clk); #1;
    n_checks++;
    if ({in_axi_arready, out_axi_rready, in_axi_rvalid, out_axi_arvalid} !== 4'b1100) begin
      n_fail++;
      $display("FAIL post_reset: arready/rready/rvalid/arvalid=%b expected 1100",
               {in_axi_arready, out_axi_rready, in_axi_rvalid, out_axi_arvalid});
    end
  endtask

  task automatic test_basic();
    bit ok;
    logic [AW-1:0] ga, ea;
    result_entry_t got, exp;
    clear_queues(); in_axi_rready = 1'b1;
    expect_burst(20'h00100, 3);
    send_req(20'h00100, 8'd3, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_accept: arready=%0b expected 1", ok); end
    wait_beats(4, 60, ok);
    n_checks++;
    if (!ok || ar_seen.size() != 4) begin
      n_fail++; $display("FAIL basic_count: beats=%0d ar=%0d expected 4/4", r_seen.size(), ar_seen.size());
    end
    while (ar_seen.size() > 0 && ar_exp.size() > 0) begin
      ga = ar_seen.pop_front(); ea = ar_exp.pop_front(); n_checks++;
      if (ga !== ea) begin n_fail++; $display("FAIL basic_araddr: got %h expected %h", ga, ea); end
    end
    while (r_seen.size() > 0 && r_exp.size() > 0) begin
      got = r_seen.pop_front(); exp = r_exp.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL basic_beat: got %h expected %h", got, exp); end
    end
    repeat (3) begin @(posedge axi_clk); #1; end
    n_checks++;
    if ({dut.state_q, in_axi_arready, in_axi_rvalid, out_axi_arvalid} !== {ST_IDLE, 3'b100}) begin
      n_fail++;
      $display("FAIL basic_idle: state/arready/rvalid/arvalid=%b expected %b",
               {dut.state_q, in_axi_arready, in_axi_rvalid, out_axi_arvalid}, {ST_IDLE, 3'b100});
    end
  endtask

  task automatic test_streaming();
    bit ok;
    result_entry_t got, exp;
    clear_queues(); in_axi_rready = 1'b1;
    expect_burst(20'h02000, 7);
    send_req(20'h02000, 8'd7, ok);
    wait_beats(8, 60, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stream_count: beats=%0d expected 8", r_seen.size()); end
    for (int i = 1; i < r_cyc.size(); i++) begin
      n_checks++;
      if (r_cyc[i] - r_cyc[i-1] != 1) begin
        n_fail++; $display("FAIL stream_bubble: beat %0d gap %0d cycles expected 1", i, r_cyc[i] - r_cyc[i-1]);
      end
    end
    while (r_seen.size() > 0 && r_exp.size() > 0) begin
      got = r_seen.pop_front(); exp = r_exp.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL stream_beat: got %h expected %h", got, exp); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [AW-1:0] ga, ea;
    result_entry_t got, exp;
    clear_queues(); in_axi_rready = 1'b0;
    expect_burst(20'h03000, 15);
    send_req(20'h03000, 8'd15, ok);
    repeat (30) begin @(posedge axi_clk); #1; end
    n_checks++;
    if (ar_seen.size() != DEPTH) begin
      n_fail++; $display("FAIL bp_issued: ar handshakes=%0d expected %0d", ar_seen.size(), DEPTH);
    end
    n_checks++;
    if ({out_axi_arvalid, in_axi_rvalid} !== 2'b01) begin
      n_fail++; $display("FAIL bp_stall: arvalid/rvalid=%b expected 01", {out_axi_arvalid, in_axi_rvalid});
    end
    in_axi_rready = 1'b1;
    wait_beats(16, 120, ok);
    n_checks++;
    if (!ok || ar_seen.size() != 16) begin
      n_fail++; $display("FAIL bp_count: beats=%0d ar=%0d expected 16/16", r_seen.size(), ar_seen.size());
    end
    while (ar_seen.size() > 0 && ar_exp.size() > 0) begin
      ga = ar_seen.pop_front(); ea = ar_exp.pop_front(); n_checks++;
      if (ga !== ea) begin n_fail++; $display("FAIL bp_araddr: got %h expected %h", ga, ea); end
    end
    while (r_seen.size() > 0 && r_exp.size() > 0) begin
      got = r_seen.pop_front(); exp = r_exp.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL bp_beat: got %h expected %h", got, exp); end
    end
  endtask

  task automatic test_overlap();
    bit ok;
    int at_accept;
    logic [4:0] lasts;
    result_entry_t got, exp;
    clear_queues(); in_axi_rready = 1'b1; lasts = '0;
    expect_burst(20'h00300, 2);
    send_req(20'h00300, 8'd2, ok);
    expect_burst(20'h00200, 1);
    send_req(20'h00200, 8'd1, ok);
    at_accept = r_seen.size();
    n_checks++;
    if (!ok || at_accept >= 3) begin
      n_fail++; $display("FAIL overlap_accept: accepted=%0b after %0d beats, expected 1 before beat 3", ok, at_accept);
    end
    wait_beats(5, 60, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL overlap_count: beats=%0d expected 5", r_seen.size()); end
    for (int i = 0; i < 5 && r_seen.size() > 0 && r_exp.size() > 0; i++) begin
      got = r_seen.pop_front(); exp = r_exp.pop_front(); lasts[i] = got.last; n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL overlap_beat: got %h expected %h", got, exp); end
    end
    n_checks++;
    if (lasts !== 5'b10100) begin n_fail++; $display("FAIL overlap_rlast: pattern %b expected 10100", lasts); end
  endtask

  task automatic test_wrap_err();
    bit ok;
    result_entry_t got, exp;
    clear_queues(); in_axi_rready = 1'b1;
    err_en = 1'b1; err_addr = 20'hFFFFE;
    expect_burst(20'hFFFFE, 1);
    send_req(20'hFFFFE, 8'd1, ok);
    wait_beats(2, 40, ok);
    n_checks++;
    if (!ok || ar_seen.size() != 2) begin
      n_fail++; $display("FAIL wrap_count: beats=%0d ar=%0d expected 2/2", r_seen.size(), ar_seen.size());
    end else begin
      n_checks++;
      if (ar_seen[0] !== 20'hFFFFE || ar_seen[1] !== 20'h00000) begin
        n_fail++; $display("FAIL wrap_araddr: got %h,%h expected fffff e,00000", ar_seen[0], ar_seen[1]);
      end
      n_checks++;
      if (r_seen[0].resp !== 2'b10 || r_seen[1].resp !== 2'b00) begin
        n_fail++; $display("FAIL wrap_rresp: got %b,%b expected 10,00", r_seen[0].resp, r_seen[1].resp);
      end
    end
    while (r_seen.size() > 0 && r_exp.size() > 0) begin
      got = r_seen.pop_front(); exp = r_exp.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL wrap_beat: got %h expected %h", got, exp); end
    end
    err_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int w;
    result_entry_t got, exp;
    clear_queues(); in_axi_rready = 1'b1; w = 0;
    send_req(20'h00400, 8'd3, ok);
    while (ar_seen.size() < 2 && w < 30) begin @(posedge axi_clk); #1; w++; end
    n_checks++;
    if (ar_seen.size() != 2) begin
      n_fail++; $display("FAIL rstmid_issued: ar handshakes=%0d expected 2", ar_seen.size());
    end else begin
      n_checks++;
      if (ar_seen[0] !== 20'h00400 || ar_seen[1] !== 20'h00402) begin
        n_fail++; $display("FAIL rstmid_araddr: got %h,%h expected 00400,00402", ar_seen[0], ar_seen[1]);
      end
    end
    axi_resetn = 1'b0;
    #1;
    n_checks++;
    if ({in_axi_arready, in_axi_rvalid, in_axi_rlast, out_axi_arvalid, out_axi_rready} !== 5'b0 ||
        {in_axi_rdata, in_axi_rresp, out_axi_araddr} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: ctrl=%b rdata=%h rresp=%b araddr=%h expected all zero",
               {in_axi_arready, in_axi_rvalid, in_axi_rlast, out_axi_arvalid, out_axi_rready},
               in_axi_rdata, in_axi_rresp, out_axi_araddr);
    end
    repeat (3) @(posedge axi_clk);
    #1 axi_resetn = 1'b1;
    repeat (5) begin @(posedge axi_clk); #1; end
    n_checks++;
    if (r_seen.size() != 0 || in_axi_arready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_clean: stale beats=%0d arready=%b expected 0/1", r_seen.size(), in_axi_arready);
    end
    clear_queues();
    expect_burst(20'h00500, 0);
    send_req(20'h00500, 8'd0, ok);
    wait_beats(1, 40, ok);
    n_checks++;
    if (!ok || ar_seen.size() != 1) begin
      n_fail++; $display("FAIL rstmid_fresh: beats=%0d ar=%0d expected 1/1", r_seen.size(), ar_seen.size());
    end
    while (r_seen.size() > 0 && r_exp.size() > 0) begin
      got = r_seen.pop_front(); exp = r_exp.pop_front(); n_checks++;
      if (got !== exp || got.last !== 1'b1) begin
        n_fail++; $display("FAIL rstmid_beat: got %h expected %h with rlast", got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_streaming();
    test_backpressure();
    test_overlap();
    test_wrap_err();
    test_reset_mid();
    repeat (2) @(posedge axi_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
